// File: rtl/branch_predict_unit_if.sv
// Branch unit bundle: fetch-side lookup, EX-side resolution,
// and performance counter readout.
interface branch_predict_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  IF_PC;
    logic             PRED_TAKEN;
    logic             EX_VALID;
    logic             BRANCH;
    logic [2:0]       FUNCT3;
    logic [XLEN-1:0]  RS1_VAL;
    logic [XLEN-1:0]  RS2_VAL;
    logic [XLEN-1:0]  EX_PC;
    logic             EX_PRED_TAKEN;
    logic             PCSrc;
    logic             MISPREDICT;
    logic             ILLEGAL;
    logic             CNT_CLR;
    logic [CNT_W-1:0] BR_COUNT;
    logic [CNT_W-1:0] MISS_COUNT;

    modport master (
        output IF_PC, EX_VALID, BRANCH, FUNCT3,
        output RS1_VAL, RS2_VAL, EX_PC, EX_PRED_TAKEN, CNT_CLR,
        input  PRED_TAKEN, PCSrc, MISPREDICT, ILLEGAL,
        input  BR_COUNT, MISS_COUNT
    );

    modport slave (
        input  IF_PC, EX_VALID, BRANCH, FUNCT3,
        input  RS1_VAL, RS2_VAL, EX_PC, EX_PRED_TAKEN, CNT_CLR,
        output PRED_TAKEN, PCSrc, MISPREDICT, ILLEGAL,
        output BR_COUNT, MISS_COUNT
    );
endinterface

// File: rtl/branch_predict_unit.sv
// RV32I branch resolution with a PC-indexed 2-bit BHT predictor
// and saturating branch/mispredict counters.
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input logic CLK,
    input logic RST_N,
    branch_predict_unit_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             res;
    logic             legal;
    logic             cond;
    logic             eq;
    logic             lts;
    logic             ltu;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic             unused;

    assign rd_idx = bus.IF_PC[IDX_W+1:2];
    assign wr_idx = bus.EX_PC[IDX_W+1:2];
    assign unused = ^{bus.IF_PC[XLEN-1:IDX_W+2], bus.IF_PC[1:0],
                      bus.EX_PC[XLEN-1:IDX_W+2], bus.EX_PC[1:0]};

    assign eq  = bus.RS1_VAL == bus.RS2_VAL;
    assign lts = $signed(bus.RS1_VAL) < $signed(bus.RS2_VAL);
    assign ltu = bus.RS1_VAL < bus.RS2_VAL;

    always_comb begin
        legal = 1'b1;
        cond  = 1'b0;
        unique case (bus.FUNCT3)
            3'b000: cond = eq;
            3'b001: cond = ~eq;
            3'b100: cond = lts;
            3'b101: cond = ~lts;
            3'b110: cond = ltu;
            3'b111: cond = ~ltu;
            default: legal = 1'b0;
        endcase
    end

    assign res            = bus.EX_VALID & bus.BRANCH;
    assign bus.PCSrc      = res & legal & cond;
    assign bus.ILLEGAL    = res & ~legal;
    assign bus.MISPREDICT = res & (bus.PCSrc != bus.EX_PRED_TAKEN);

    // Read is from the registered table: a same-index update is not bypassed.
    assign bus.PRED_TAKEN = bht[rd_idx][1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (res && legal) begin
            if (cond) begin
                if (bht[wr_idx] != 2'b11) begin
                    bht[wr_idx] <= bht[wr_idx] + 2'b01;
                end
            end else begin
                if (bht[wr_idx] != 2'b00) begin
                    bht[wr_idx] <= bht[wr_idx] - 2'b01;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            br_cnt   <= '0;
            miss_cnt <= '0;
        end else if (bus.CNT_CLR) begin
            br_cnt   <= '0;
            miss_cnt <= '0;
        end else if (res) begin
            if (br_cnt != '1) begin
                br_cnt <= br_cnt + 1'b1;
            end
            if (bus.MISPREDICT && miss_cnt != '1) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

    assign bus.BR_COUNT   = br_cnt;
    assign bus.MISS_COUNT = miss_cnt;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: driver queues expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_branch_predict_unit;
    localparam int XLEN = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        string      nm;
        logic       pcsrc;
        logic       mis;
        logic       ill;
        logic       pred;
        logic [CW-1:0] br;
        logic [CW-1:0] miss;
    } exp_t;

    logic CLK;
    logic RST_N;
    int   n_assert;
    int   n_fail;
    int   m_br;
    int   m_miss;
    exp_t q[$];

    branch_predict_unit_if #(.XLEN(XLEN), .CNT_W(CW)) bus ();

    branch_predict_unit #(
        .XLEN(XLEN),
        .BHT_ENTRIES(16),
        .CNT_W(CW)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input string f,
                       input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, f, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, "PCSrc", int'(bus.PCSrc), int'(e.pcsrc));
            chk(e.nm, "MISPREDICT", int'(bus.MISPREDICT), int'(e.mis));
            chk(e.nm, "ILLEGAL", int'(bus.ILLEGAL), int'(e.ill));
            chk(e.nm, "PRED_TAKEN", int'(bus.PRED_TAKEN), int'(e.pred));
            chk(e.nm, "BR_COUNT", int'(bus.BR_COUNT), int'(e.br));
            chk(e.nm, "MISS_COUNT", int'(bus.MISS_COUNT), int'(e.miss));
        end
    end

    task automatic step(input string nm, input logic rst,
                        input logic v, input logic [2:0] f3,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] ex_pc, input logic ep,
                        input logic [31:0] if_pc, input logic clr,
                        input logic e_pcsrc, input logic e_mis,
                        input logic e_ill, input logic e_pred);
        exp_t e;
        @(posedge CLK);
        #1;
        RST_N             = rst;
        bus.EX_VALID      = v;
        bus.BRANCH        = v;
        bus.FUNCT3        = f3;
        bus.RS1_VAL       = rs1;
        bus.RS2_VAL       = rs2;
        bus.EX_PC         = ex_pc;
        bus.EX_PRED_TAKEN = ep;
        bus.IF_PC         = if_pc;
        bus.CNT_CLR       = clr;
        if (!rst) begin
            m_br   = 0;
            m_miss = 0;
        end
        e.nm    = nm;
        e.pcsrc = e_pcsrc;
        e.mis   = e_mis;
        e.ill   = e_ill;
        e.pred  = e_pred;
        e.br    = CW'(m_br);
        e.miss  = CW'(m_miss);
        q.push_back(e);
        if (rst) begin
            if (clr) begin
                m_br   = 0;
                m_miss = 0;
            end else if (v) begin
                if (m_br < CMAX) m_br++;
                if (e_mis && m_miss < CMAX) m_miss++;
            end
        end
    endtask

    task automatic idle(input string nm, input logic [31:0] if_pc,
                        input logic clr, input logic e_pred);
        step(nm, 1'b1, 1'b0, 3'b000, 0, 0, 0, 1'b0, if_pc, clr,
             1'b0, 1'b0, 1'b0, e_pred);
    endtask

    task automatic br(input string nm, input logic [2:0] f3,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] ex_pc, input logic ep,
                      input logic [31:0] if_pc, input logic clr,
                      input logic e_pcsrc, input logic e_mis,
                      input logic e_ill, input logic e_pred);
        step(nm, 1'b1, 1'b1, f3, rs1, rs2, ex_pc, ep, if_pc, clr,
             e_pcsrc, e_mis, e_ill, e_pred);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        m_br     = 0;
        m_miss   = 0;
        RST_N             = 1'b0;
        bus.IF_PC         = '0;
        bus.EX_VALID      = 1'b0;
        bus.BRANCH        = 1'b0;
        bus.FUNCT3        = 3'b000;
        bus.RS1_VAL       = '0;
        bus.RS2_VAL       = '0;
        bus.EX_PC         = '0;
        bus.EX_PRED_TAKEN = 1'b0;
        bus.CNT_CLR       = 1'b0;
        repeat (2) @(posedge CLK);

        for (int i = 0; i < 16; i++) begin
            idle($sformatf("sweep%0d", i), 32'(i * 4), 1'b0, 1'b0);
        end

        br("beq", 3'b000, 5, 5, 32'h100, 1, 32'h3C, 0, 1, 0, 0, 0);
        br("bne", 3'b001, 5, 5, 32'h100, 0, 32'h3C, 0, 0, 0, 0, 0);

        br("blt",  3'b100, 32'hFFFF_FFFF, 1, 32'h104, 1, 32'h3C, 0, 1, 0, 0, 0);
        br("bge",  3'b101, 32'hFFFF_FFFF, 1, 32'h104, 0, 32'h3C, 0, 0, 0, 0, 0);
        br("bltu", 3'b110, 32'hFFFF_FFFF, 1, 32'h104, 0, 32'h3C, 0, 0, 0, 0, 0);
        br("bgeu", 3'b111, 32'hFFFF_FFFF, 1, 32'h104, 1, 32'h3C, 0, 1, 0, 0, 0);

        br("sat_t1", 3'b000, 5, 5, 32'h40, 0, 32'h40, 0, 1, 1, 0, 0);
        br("sat_t2", 3'b000, 5, 5, 32'h40, 1, 32'h40, 0, 1, 0, 0, 1);
        br("sat_t3", 3'b000, 5, 5, 32'h40, 1, 32'h40, 0, 1, 0, 0, 1);
        br("sat_t4", 3'b000, 5, 5, 32'h40, 1, 32'h40, 0, 1, 0, 0, 1);
        br("sat_n1", 3'b000, 5, 6, 32'h40, 1, 32'h40, 0, 0, 1, 0, 1);
        br("sat_n2", 3'b000, 5, 6, 32'h40, 1, 32'h40, 0, 0, 1, 0, 1);
        br("sat_n3", 3'b000, 5, 6, 32'h40, 0, 32'h40, 0, 0, 0, 0, 0);
        idle("sat_idle", 32'h40, 0, 0);
        br("sat_floor", 3'b000, 5, 5, 32'h40, 0, 32'h40, 0, 1, 1, 0, 0);
        idle("sat_floor_idle", 32'h40, 0, 0);

        idle("clr", 32'h3C, 1, 0);

        br("coll", 3'b000, 7, 7, 32'h4C, 0, 32'h8C, 0, 1, 1, 0, 0);
        idle("coll_next", 32'h0C, 0, 1);

        br("ill010", 3'b010, 5, 5, 32'h0C, 1, 32'h0C, 0, 0, 1, 1, 1);
        idle("ill010_idle", 32'h0C, 0, 1);
        br("ill011", 3'b011, 5, 5, 32'h0C, 0, 32'h0C, 0, 0, 0, 1, 1);
        idle("ill011_idle", 32'h0C, 0, 1);

        for (int i = 0; i < 20; i++) begin
            br($sformatf("miss%0d", i), 3'b000, 5, 6, 32'h200, 1,
               32'h3C, 0, 0, 1, 0, 0);
        end
        idle("cnt_sat", 32'h3C, 0, 0);
        br("clr_br", 3'b000, 5, 6, 32'h200, 1, 32'h3C, 1, 0, 1, 0, 0);
        idle("clr_after", 32'h3C, 0, 0);

        br("pre_rst", 3'b000, 5, 6, 32'h200, 1, 32'h0C, 0, 0, 1, 0, 1);
        idle("pre_rst_idle", 32'h0C, 0, 1);
        step("async_rst", 1'b0, 1'b0, 3'b000, 0, 0, 0, 1'b0, 32'h0C, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b0);
        idle("post_rst", 32'h0C, 0, 0);

        @(negedge CLK);
        #1;
        chk("end", "queue_left", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
